// File: rtl/debounce_multi.sv
// Multi-channel pushbutton conditioner: synchroniser, debounce, press/release
// strobes, long-press level and auto-repeat strobe per channel.
module debounce_multi #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 1000000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_LIMIT     = 50000000,
  parameter int unsigned REPEAT_PERIOD  = 10000000,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] rpt
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_LIMIT);
  localparam int unsigned HW      = $clog2(HOLD_LIMIT + 1);
  localparam int unsigned PW      = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int unsigned RP_LAST = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          db_cnt_q, db_cnt_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]          per_cnt_q, per_cnt_d;
    logic                   deb_q, deb_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   held_q, held_d;
    logic                   rpt_q, rpt_d;

    assign s = sync_q[SYNC_STAGES-1];

    // State registers; reset returns the channel to "released" with no strobes.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q     <= '0;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        per_cnt_q  <= '0;
        deb_q      <= 1'b0;
        rise_q     <= 1'b0;
        fall_q     <= 1'b0;
        held_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], bouncy[i] ^ ACTIVE_LOW};
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        per_cnt_q  <= per_cnt_d;
        deb_q      <= deb_d;
        rise_q     <= rise_d;
        fall_q     <= fall_d;
        held_q     <= held_d;
        rpt_q      <= rpt_d;
      end
    end

    // Next-state: debounce, then hold/repeat keyed off the accepted level.
    always_comb begin
      db_cnt_d   = '0;
      deb_d      = deb_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      hold_cnt_d = hold_cnt_q;
      held_d     = 1'b0;
      per_cnt_d  = '0;
      rpt_d      = 1'b0;

      if (s != deb_q) begin
        if (db_cnt_q == DW'(DEBOUNCE_LIMIT - 1)) begin
          deb_d  = s;
          rise_d = s;
          fall_d = ~s;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      // A release clears the hold state on the same edge that raises fall.
      if (!deb_q || fall_d) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q != HW'(HOLD_LIMIT)) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      held_d = (hold_cnt_d == HW'(HOLD_LIMIT));

      if (held_d) begin
        if (!held_q) begin
          rpt_d = 1'b1;
        end else if (REPEAT_PERIOD > 0) begin
          if (per_cnt_q == PW'(RP_LAST)) begin
            rpt_d = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + 1'b1;
          end
        end
      end
    end

    assign debounced[i] = deb_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;
    assign held[i]      = held_q;
    assign rpt[i]       = rpt_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: N_CH=2, DEBOUNCE_LIMIT=4, SYNC_STAGES=2,
// HOLD_LIMIT=10, REPEAT_PERIOD=3, plus an ACTIVE_LOW=1 instance.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bouncy, bouncy_al;
  logic [1:0] debounced, rise, fall, held, rpt;
  logic [1:0] debounced_al, rise_al, fall_al, held_al, rpt_al;
  logic [9:0] obs, obs_al;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(2), .DEBOUNCE_LIMIT(4), .SYNC_STAGES(2),
    .HOLD_LIMIT(10), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .bouncy(bouncy),
    .debounced(debounced), .rise(rise), .fall(fall), .held(held), .rpt(rpt)
  );

  debounce_multi #(
    .N_CH(2), .DEBOUNCE_LIMIT(4), .SYNC_STAGES(2),
    .HOLD_LIMIT(10), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .bouncy(bouncy_al),
    .debounced(debounced_al), .rise(rise_al), .fall(fall_al), .held(held_al), .rpt(rpt_al)
  );

  assign obs    = {debounced, rise, fall, held, rpt};
  assign obs_al = {debounced_al, rise_al, fall_al, held_al, rpt_al};

  // Expected {debounced,rise,fall,held,rpt} with channel 1 idle.
  function automatic logic [9:0] exp0(input bit d, input bit r, input bit f,
                                      input bit h, input bit p);
    return {1'b0, d, 1'b0, r, 1'b0, f, 1'b0, h, 1'b0, p};
  endfunction

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bouncy    = 2'b00;
    bouncy_al = 2'b11;
    apply_reset();
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", obs, 10'b0);
    end
    n_checks++;
    if (obs_al !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state_al: got %b want %b", obs_al, 10'b0);
    end
  endtask

  task automatic test_clean_press();
    logic [9:0] e;
    bouncy = 2'b00;
    apply_reset();
    bouncy = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = exp0(k >= 6, k == 6, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL clean_press step %0d: got %b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] e;
    bouncy = 2'b00;
    apply_reset();
    for (int ph = 0; ph < 4; ph++) begin
      bouncy = (ph % 2 == 0) ? 2'b01 : 2'b00;
      for (int k = 0; k < 3; k++) begin
        step();
        n_checks++;
        if (obs !== 10'b0) begin
          n_fail++;
          $display("FAIL bounce_reject phase %0d: got %b want %b", ph, obs, 10'b0);
        end
      end
    end
    bouncy = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = exp0(k >= 6, k == 6, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bounce_settle step %0d: got %b want %b", k, obs, e);
      end
    end
  endtask

  // Press to F, repeats at F+10 and F+13, release so that fall lands on F+19,
  // which would otherwise be a repeat edge.
  task automatic test_long_press_release();
    logic [9:0] e;
    bouncy = 2'b00;
    apply_reset();
    bouncy = 2'b01;
    for (int k = 1; k <= 6; k++) step();
    n_checks++;
    if (obs !== exp0(1, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL press_edge_F: got %b want %b", obs, exp0(1, 1, 0, 0, 0));
    end
    for (int j = 1; j <= 24; j++) begin
      if (j == 14) bouncy = 2'b00;
      step();
      e = exp0(j < 19, 1'b0, j == 19, (j >= 10) && (j < 19),
               (j == 10) || (j == 13) || (j == 16));
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL hold_repeat_release F+%0d: got %b want %b", j, obs, e);
      end
    end
    // A fresh press must run the full hold count again.
    bouncy = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step();
      e = exp0(k >= 6, k == 6, 1'b0, k == 16, k == 16);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL repress step %0d: got %b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    bouncy = 2'b00;
    apply_reset();
    bouncy = 2'b01;
    for (int k = 1; k <= 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b want %b", obs, 10'b0);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      e = exp0(k >= 6, k == 6, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_recount step %0d: got %b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_active_low();
    logic [9:0] e;
    bouncy_al = 2'b11;
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (obs_al !== 10'b0) begin
        n_fail++;
        $display("FAIL active_low_idle step %0d: got %b want %b", k, obs_al, 10'b0);
      end
    end
    bouncy_al = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = exp0(k >= 6, k == 6, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs_al !== e) begin
        n_fail++;
        $display("FAIL active_low_press step %0d: got %b want %b", k, obs_al, e);
      end
    end
    bouncy_al = 2'b11;
  endtask

  initial begin
    rst       = 1'b1;
    bouncy    = 2'b00;
    bouncy_al = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press_release();
    test_reset_mid();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel button conditioner that replaces the single-channel debouncer in the stopwatch front end. Each channel synchronises a raw pushbutton input, rejects bounce with its own stability counter, and outputs a clean level, one-cycle press/release strobes, a long-press flag and an auto-repeat strobe. It sits between the board buttons and the stopwatch control FSM. All channels share one clock and one reset.

## Interface

Parameters:
- N_CH, default 4: number of independent channels, ≥1.
- DEBOUNCE_LIMIT, default 1000000: consecutive cycles an input must hold a new value before it is accepted, ≥2.
- SYNC_STAGES, default 2: flops in each input synchroniser, ≥2.
- HOLD_LIMIT, default 50000000: cycles of stable press before `held` asserts, ≥1.
- REPEAT_PERIOD, default 10000000: cycles between `rpt` strobes while held. A value of 0 means one `rpt` at hold entry only.
- ACTIVE_LOW, default 0: when 1, `bouncy` is inverted at the input so all outputs mean "pressed".

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- bouncy, in, N_CH: raw asynchronous button inputs.
- debounced, out, N_CH: accepted, stable pressed level.
- rise, out, N_CH: one-cycle strobe when `debounced` goes 0→1.
- fall, out, N_CH: one-cycle strobe when `debounced` goes 1→0.
- held, out, N_CH: level; the channel has been pressed for at least HOLD_LIMIT cycles.
- rpt, out, N_CH: one-cycle auto-repeat strobe.

## Operation

- Every channel runs identical, independent logic. No channel affects another.
- Input path:
  - Apply `bouncy[i]` XOR ACTIVE_LOW.
  - Pass the result through a SYNC_STAGES flop chain. The last stage is `s[i]`.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_LIMIT).
  - When `s[i]` equals `debounced[i]`, the counter clears to 0.
  - When they differ and the counter is below DEBOUNCE_LIMIT-1, the counter increments.
  - When they differ and the counter equals DEBOUNCE_LIMIT-1, `debounced[i]` takes `s[i]` and the counter clears.
- Any return of `s[i]` to the accepted value before the limit discards the partial count.
- `rise` and `fall` are registered. Each is high for exactly the one cycle in which `debounced` shows its new value.
- Hold counter:
  - Clears whenever `debounced[i]` is 0.
  - Increments each cycle `debounced[i]` is 1 and saturates at HOLD_LIMIT.
  - `held[i]` is 1 exactly when the count equals HOLD_LIMIT.
- Repeat:
  - `rpt[i]` pulses on the cycle `held[i]` first asserts.
  - With REPEAT_PERIOD>0 it then pulses every REPEAT_PERIOD cycles while held. A period counter wraps from REPEAT_PERIOD-1 to 0 and emits `rpt`.
- Release on a fall: hold count, period counter and `held` all clear on the same edge that asserts `fall`. No `rpt` may occur on that edge.
- Reset:
  - Clears synchroniser flops, all counters and all outputs to 0 (logical "released").
  - With ACTIVE_LOW=1 an idle-high input is therefore already in agreement after reset.
- Reset asserted mid-count or mid-hold aborts everything. No strobes are emitted during or on release of reset.

## Timing

- Let E be the first rising edge that samples a new, steady `bouncy` value. Then:
  - `debounced` updates at edge E+SYNC_STAGES+DEBOUNCE_LIMIT-1.
  - `rise` or `fall` is high in the cycle following that edge.
- Rejection: a pulse on `s[i]` lasting ≤ DEBOUNCE_LIMIT-1 cycles never changes `debounced`.
- Let F be the edge at which `debounced` rises. Then:
  - `held` asserts at edge F+HOLD_LIMIT.
  - `rpt` pulses at edges F+HOLD_LIMIT+k·REPEAT_PERIOD, for k=0,1,2,…
- `rise` and `fall` are never both high on one channel. `rpt` never coincides with `rise`.
- If the debounce threshold is reached on the same edge `s[i]` reverts, the comparison uses the current `s[i]`. That means no update and the counter clears.

## Test plan

Parameters for all cases: N_CH=2, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, HOLD_LIMIT=10, REPEAT_PERIOD=3, ACTIVE_LOW=0.

- Clean press: `bouncy[0]` 0→1 sampled at edge 0 → `debounced[0]`=1 after edge 5, `rise[0]` high only in the cycle after edge 5, `fall`=0, channel 1 outputs stay 0.
- Bounce rejection: `bouncy[0]` toggles 1,0,1,0 every 3 cycles, then holds 1 → no `rise` during the toggling; `debounced` rises 5 edges after the final steady sample.
- Long press and repeat: hold `bouncy[0]`=1 with `debounced` rising at edge F → `held` asserts at F+10; `rpt` pulses at F+10, F+13 and F+16; `rpt` is silent otherwise.
- Release while held: drop `bouncy[0]` after 2 repeats → `fall` pulses; `held`, `rpt` and the counters clear on that edge; no further `rpt`.
- Reset mid-count: assert `rst` for 1 cycle while the debounce counter is at 2 → all outputs 0; the press needs a full 4-cycle count again; no strobe is emitted on reset release.
- ACTIVE_LOW=1 with idle `bouncy`=1 after reset → outputs stay 0; driving 0 produces `rise` with the same latency as the clean-press case.
